// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: sizing helpers, parameter legality
// checks and the status bundle that every FIFO variant reports.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostFull;
    logic almostEmpty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int ptrWidth(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < depth) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit isPow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit paramsLegal(input int dataW, input int depth,
                                     input int af, input int ae, input int fwft);
    return (dataW >= 1) && isPow2(depth) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with thresholds, occupancy count, sticky
// error flags, synchronous clear and optional first-word-fall-through read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = ptrWidth(DEPTH);
  localparam int CW = PW + 1;
  localparam bit FwftMode = (FWFT != 0);

  if (!paramsLegal(DATA_W, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : gBadParams
    $error("sync_fifo_param: illegal parameter combination");
  end

  logic [PW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rdData_q, rdData_d, memRdata;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wrAccept, rdAccept;
  fifo_status_t      status;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PW)
  ) uMem (
    .clk       (clk),
    .wr_en_i   (wrAccept),
    .wr_addr_i (wrPtr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rdPtr_q),
    .rd_data_o (memRdata)
  );

  // Flags come only from registered state, so request inputs never reach them.
  always_comb begin
    status             = '0;
    status.full        = (count_q == CW'(DEPTH));
    status.empty       = (count_q == '0);
    status.almostFull  = (count_q >= CW'(AF_THRESH));
    status.almostEmpty = (count_q <= CW'(AE_THRESH));
    status.overflow    = overflow_q;
    status.underflow   = underflow_q;
  end

  assign wrAccept = wr_en && !status.full;
  assign rdAccept = rd_en && !status.empty;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    rdData_d    = rdData_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      rdData_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wrAccept) wrPtr_d = wrPtr_q + PW'(1);
      if (rdAccept) rdPtr_d = rdPtr_q + PW'(1);
      case ({wrAccept, rdAccept})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (!FwftMode && rdAccept) rdData_d = memRdata;
      if (wr_en && status.full)  overflow_d  = 1'b1;
      if (rd_en && status.empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      rdData_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      rdData_q    <= rdData_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // In FWFT mode the head word is shown directly; while empty the cleared register shows through.
  assign rd_data      = (FwftMode && !status.empty) ? memRdata : rdData_q;
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almostFull;
  assign almost_empty = status.almostEmpty;
  assign count        = count_q;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a standard-read and an FWFT instance share stimulus and
// are compared each cycle against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              wrEn;
  logic [DATA_W-1:0] wrData;
  logic              rdEn;

  logic [DATA_W-1:0] rdDataS, rdDataF;
  logic              fullS, emptyS, afS, aeS, ovfS, udfS;
  logic              fullF, emptyF, afF, aeF, ovfF, udfF;
  logic [3:0]        countS, countF;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] modelQ[$];
  logic [DATA_W-1:0] expRd;
  logic              expOvf;
  logic              expUdf;

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
  ) dutStd (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wrEn), .wr_data(wrData),
    .rd_en(rdEn), .rd_data(rdDataS), .full(fullS), .empty(emptyS),
    .almost_full(afS), .almost_empty(aeS), .count(countS),
    .overflow(ovfS), .underflow(udfS)
  );

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
  ) dutFwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wrEn), .wr_data(wrData),
    .rd_en(rdEn), .rd_data(rdDataF), .full(fullF), .empty(emptyF),
    .almost_full(afF), .almost_empty(aeF), .count(countF),
    .overflow(ovfF), .underflow(udfF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    modelQ.delete();
    expRd  = '0;
    expOvf = 1'b0;
    expUdf = 1'b0;
  endtask

  // One clock of the behavioural model, using occupancy before the edge.
  task automatic modelStep(input logic w, input logic [DATA_W-1:0] d,
                           input logic r, input logic c);
    int  n;
    logic wa, ra;
    n = modelQ.size();
    if (c) begin
      resetModel();
    end else begin
      wa = w && (n != DEPTH);
      ra = r && (n != 0);
      if (w && n == DEPTH) expOvf = 1'b1;
      if (r && n == 0)     expUdf = 1'b1;
      if (ra) expRd = modelQ.pop_front();
      if (wa) modelQ.push_back(d);
    end
  endtask

  task automatic checkOutput();
    int n;
    n = modelQ.size();
    check("count",       32'(countS), 32'(n));
    check("full",        32'(fullS),  32'(n == DEPTH));
    check("empty",       32'(emptyS), 32'(n == 0));
    check("almostFull",  32'(afS),    32'(n >= AF));
    check("almostEmpty", 32'(aeS),    32'(n <= AE));
    check("overflow",    32'(ovfS),   32'(expOvf));
    check("underflow",   32'(udfS),   32'(expUdf));
    check("rdData",      32'(rdDataS), 32'(expRd));
    check("fwftCount",   32'(countF), 32'(n));
    check("fwftEmpty",   32'(emptyF), 32'(n == 0));
    check("fwftOvf",     32'(ovfF),   32'(expOvf));
    if (n != 0) check("fwftRdData", 32'(rdDataF), 32'(modelQ[0]));
  endtask

  // Drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic applyStimulus(input logic w, input logic [DATA_W-1:0] d,
                               input logic r, input logic c);
    wrEn   = w;
    wrData = d;
    rdEn   = r;
    clr    = c;
    @(posedge clk);
    modelStep(w, d, r, c);
    @(negedge clk);
    checkOutput();
    wrEn = 1'b0;
    rdEn = 1'b0;
    clr  = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    wrData = '0;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput();
    rst_n = 1'b1;

    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    check("fullAfterFill", 32'(fullS), 32'(1));

    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0);
    check("overflowSet", 32'(ovfS), 32'(1));

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      check("drainOrder", 32'(rdDataS), 32'(i));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check("underflowSet", 32'(udfS), 32'(1));
    check("rdDataHeld", 32'(rdDataS), 32'(8'h08));

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
      check("wrapCount", 32'(countS), 32'(3));
      check("wrapOrder", 32'(rdDataS), 32'(8'h20 + i - 3));
    end

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    check("fwftHead", 32'(rdDataF), 32'(8'hA5));
    check("fwftNotEmpty", 32'(emptyF), 32'(0));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwftPopEmpty", 32'(emptyF), 32'(1));

    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check("preClrCount", 32'(countS), 32'(5));
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    check("clrCount", 32'(countS), 32'(0));
    check("clrOverflow", 32'(ovfS), 32'(0));

    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 resetModel();
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
